dr_zero_count_mod: RTL and testbench

Clocked, parametrised successor to the dual-rail even-zeroes detector. Accepts single-bit tokens on a dual-rail, four-phase (return-to-zero) input channel. Counts the received 0 bits (or 1 bits, selectable) modulo `MODULUS` and answers each token on a dual-rail output pair that doubles as the acknowledge. Sits between an asynchronous dual-rail producer and synchronous logic; the inputs are synchronised internally.

---
 rtl/dr_zero_count_mod.sv | 121 ++++++++++++
 tb/tb_dr_zero_count_mod.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dr_zero_count_mod.sv
// rtl/dr_zero_count_mod.sv - dual-rail four-phase token counter modulo MODULUS with dual-rail result/ack
module dr_zero_count_mod #(
    parameter int MODULUS     = 2,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit0,
    input  logic          bit1,
    input  logic          count_ones,
    output logic          parity0,
    output logic          parity1,
    output logic [CW-1:0] count,
    output logic          err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MODULUS - 1);

    logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   parity0_q, parity0_d;
    logic                   parity1_q, parity1_d;
    logic                   err_q, err_d;

    logic          s0, s1;
    logic          counted;
    logic [CW-1:0] count_next;

    // Rails enter at the LSB and shift toward the MSB, which feeds the FSM.
    always_comb begin
        sync0_d = {sync0_q[SYNC_STAGES-2:0], bit0};
        sync1_d = {sync1_q[SYNC_STAGES-2:0], bit1};
    end

    assign s0 = sync0_q[SYNC_STAGES-1];
    assign s1 = sync1_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q   <= '0;
            sync1_q   <= '0;
            state_q   <= IDLE;
            count_q   <= '0;
            parity0_q <= 1'b0;
            parity1_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            state_q   <= state_d;
            count_q   <= count_d;
            parity0_q <= parity0_d;
            parity1_q <= parity1_d;
            err_q     <= err_d;
        end
    end

    // A rail swap in HOLD keeps exactly one rail high, so it never leaves HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (s0 ^ s1) state_d = HOLD;
            HOLD: if (!s0 && !s1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        counted    = count_ones ? s1 : s0;
        count_next = count_q;
        if (counted) begin
            count_next = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
        end
    end

    always_comb begin
        count_d   = count_q;
        parity0_d = parity0_q;
        parity1_d = parity1_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                parity0_d = 1'b0;
                parity1_d = 1'b0;
                if (s0 ^ s1) begin
                    count_d   = count_next;
                    parity1_d = (count_next == '0);
                    parity0_d = (count_next != '0);
                end else if (s0 && s1) begin
                    err_d = 1'b1;
                end
            end
            HOLD: begin
                if (s0 && s1) begin
                    err_d = 1'b1;
                end else if (!s0 && !s1) begin
                    parity0_d = 1'b0;
                    parity1_d = 1'b0;
                end
            end
            default: begin
                parity0_d = 1'b0;
                parity1_d = 1'b0;
            end
        endcase
    end

    assign parity0 = parity0_q;
    assign parity1 = parity1_q;
    assign count   = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dr_zero_count_mod.sv
// tb/tb_dr_zero_count_mod.sv - directed-vector bench for dr_zero_count_mod
module tb_dr_zero_count_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit0, bit1, count_ones;
    logic       d2_p0, d2_p1, d2_err;
    logic [0:0] d2_count;
    logic       d3_p0, d3_p1, d3_err;
    logic [1:0] d3_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dr_zero_count_mod #(.MODULUS(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .bit0(bit0), .bit1(bit1), .count_ones(count_ones),
        .parity0(d2_p0), .parity1(d2_p1), .count(d2_count), .err(d2_err)
    );

    dr_zero_count_mod #(.MODULUS(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst(rst), .bit0(bit0), .bit1(bit1), .count_ones(count_ones),
        .parity0(d3_p0), .parity1(d3_p1), .count(d3_count), .err(d3_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int obs_p0(input bit sel3);
        return sel3 ? int'(d3_p0) : int'(d2_p0);
    endfunction

    function automatic int obs_p1(input bit sel3);
        return sel3 ? int'(d3_p1) : int'(d2_p1);
    endfunction

    function automatic int obs_cnt(input bit sel3);
        return sel3 ? int'(d3_count) : int'(d2_count);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Rail set at a falling edge; the next rising edge is the first sample.
    task automatic send_token(input logic val, input bit sel3, input int exp_cnt,
                              input int exp_p1, input bit do_release,
                              input bit toggle_mode, input string tag);
        @(negedge clk);
        if (val) bit1 = 1'b1;
        else     bit0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_early"}, obs_p0(sel3) | obs_p1(sel3), 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_p0"}, obs_p0(sel3), 1 - exp_p1);
        chk({tag, "_p1"}, obs_p1(sel3), exp_p1);
        chk({tag, "_cnt"}, obs_cnt(sel3), exp_cnt);
        if (toggle_mode) begin
            count_ones = ~count_ones;
            repeat (2) @(negedge clk);
            chk({tag, "_frozen"}, obs_cnt(sel3), exp_cnt);
            count_ones = ~count_ones;
        end
        if (do_release) begin
            bit0 = 1'b0;
            bit1 = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_held"}, obs_p0(sel3) | obs_p1(sel3), 1);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_clr"}, obs_p0(sel3) | obs_p1(sel3), 0);
            chk({tag, "_cnt_kept"}, obs_cnt(sel3), exp_cnt);
        end
    endtask

    initial begin
        int nz;
        rst        = 1'b1;
        bit0       = 1'b1;
        bit1       = 1'b0;
        count_ones = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", int'(d2_p0) + int'(d2_p1) + int'(d2_count) + int'(d2_err), 0);
        chk("rst_outs3", int'(d3_p0) + int'(d3_p1) + int'(d3_count) + int'(d3_err), 0);
        bit0 = 1'b0;
        rst  = 1'b0;
        nz   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d2_p0 || d2_p1 || d2_count != 0 || d2_err) nz++;
        end
        chk("idle_quiet", nz, 0);

        send_token(1'b0, 1'b0, 1, 0, 1'b1, 1'b0, "par_t0");
        send_token(1'b1, 1'b0, 1, 0, 1'b1, 1'b0, "par_t1");
        send_token(1'b0, 1'b0, 0, 1, 1'b1, 1'b0, "par_t2");
        send_token(1'b0, 1'b0, 1, 0, 1'b1, 1'b0, "par_t3");

        apply_reset();
        send_token(1'b0, 1'b1, 1, 0, 1'b1, 1'b0, "mod3_t0");
        send_token(1'b0, 1'b1, 2, 0, 1'b1, 1'b0, "mod3_t1");
        send_token(1'b0, 1'b1, 0, 1, 1'b1, 1'b0, "mod3_t2");
        send_token(1'b0, 1'b1, 1, 0, 1'b1, 1'b0, "mod3_t3");
        send_token(1'b0, 1'b1, 2, 0, 1'b1, 1'b0, "mod3_t4");

        apply_reset();
        count_ones = 1'b1;
        send_token(1'b1, 1'b0, 1, 0, 1'b1, 1'b1, "ones_t0");
        send_token(1'b1, 1'b0, 0, 1, 1'b1, 1'b0, "ones_t1");
        send_token(1'b0, 1'b0, 0, 1, 1'b1, 1'b0, "ones_t2");
        count_ones = 1'b0;

        apply_reset();
        @(negedge clk);
        bit0 = 1'b1;
        bit1 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("err_early", int'(d2_err), 0);
        @(posedge clk);
        @(negedge clk);
        chk("err_set", int'(d2_err), 1);
        chk("err_noack", int'(d2_p0) | int'(d2_p1), 0);
        chk("err_cnt", int'(d2_count), 0);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (4) @(negedge clk);
        send_token(1'b0, 1'b0, 1, 0, 1'b1, 1'b0, "err_tok");
        chk("err_sticky", int'(d2_err), 1);

        apply_reset();
        chk("err_cleared", int'(d2_err), 0);
        send_token(1'b0, 1'b0, 1, 0, 1'b1, 1'b0, "rh_t0");
        send_token(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, "rh_t1");
        #2 rst = 1'b1;
        #1;
        chk("rh_async_p1", int'(d2_p1), 0);
        chk("rh_async_cnt", int'(d2_count), 0);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_token(1'b0, 1'b0, 1, 0, 1'b1, 1'b0, "rh_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
